// File: rtl/vc_arbiter_if.sv
// Handshake bundle between the VC FIFOs, the destination FIFOs and vc_arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding FIFO/flow-control side.
interface vc_arbiter_if #(
  parameter int DATA_WIDTH = 6
);
  logic                  active_in;
  logic                  vc0_empty;
  logic                  vc1_empty;
  logic [DATA_WIDTH-1:0] vc0_data;
  logic [DATA_WIDTH-1:0] vc1_data;
  logic                  d0_almost_full;
  logic                  d1_almost_full;
  logic                  vc0_pop;
  logic                  vc1_pop;
  logic                  d0_push;
  logic                  d1_push;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  arb_idle;

  modport master (
    output active_in, vc0_empty, vc1_empty, vc0_data, vc1_data,
           d0_almost_full, d1_almost_full,
    input  vc0_pop, vc1_pop, d0_push, d1_push, data_out, arb_idle
  );

  modport slave (
    input  active_in, vc0_empty, vc1_empty, vc0_data, vc1_data,
           d0_almost_full, d1_almost_full,
    output vc0_pop, vc1_pop, d0_push, d1_push, data_out, arb_idle
  );
endinterface

// File: rtl/vc_arbiter.sv
// Weighted round-robin scheduler from two FWFT VC FIFOs into the D0/D1 destination FIFOs.
// Define VC_ARB_STRICT_PRIO_EN to replace the weighted scheme with fixed VC0-over-VC1 priority.
module vc_arbiter #(
  parameter int DATA_WIDTH = 6,
  parameter int DEST_BIT   = 4,
  parameter int WEIGHT_VC0 = 3,
  parameter int WEIGHT_VC1 = 1
) (
  input  logic        clk,
  input  logic        reset,
  vc_arbiter_if.slave arb
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN_VC0 = 2'd1,
    OWN_VC1 = 2'd2
  } state_e;

  localparam logic [3:0] W0 = 4'(WEIGHT_VC0);
  localparam logic [3:0] W1 = 4'(WEIGHT_VC1);

  // Grant counter saturates at the owning VC's weight.
  function automatic logic [3:0] sat_inc(input logic [3:0] c, input logic [3:0] lim);
    return (c >= lim) ? lim : c + 4'd1;
  endfunction

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  d0_push_q, d0_push_d;
  logic                  d1_push_q, d1_push_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  idle_q;

  logic                  e0, e1;
  logic                  gnt0, gnt1;
  logic                  any_gnt;
  logic [DATA_WIDTH-1:0] gnt_word;
  logic                  af0_sel, af1_sel;

  // A VC is eligible only if the destination of its own head word has room.
  always_comb begin
    af0_sel = arb.vc0_data[DEST_BIT] ? arb.d1_almost_full : arb.d0_almost_full;
    af1_sel = arb.vc1_data[DEST_BIT] ? arb.d1_almost_full : arb.d0_almost_full;
    e0      = arb.active_in & ~arb.vc0_empty & ~af0_sel;
    e1      = arb.active_in & ~arb.vc1_empty & ~af1_sel;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
`ifdef VC_ARB_STRICT_PRIO_EN
    if (e0) begin
      gnt0    = 1'b1;
      state_d = OWN_VC0;
      cnt_d   = 4'd1;
    end else if (e1) begin
      gnt1    = 1'b1;
      state_d = OWN_VC1;
      cnt_d   = 4'd1;
    end else begin
      state_d = IDLE;
      cnt_d   = 4'd0;
    end
`else
    unique case (state_q)
      IDLE: begin
        if (e0) begin
          gnt0    = 1'b1;
          state_d = OWN_VC0;
          cnt_d   = 4'd1;
        end else if (e1) begin
          gnt1    = 1'b1;
          state_d = OWN_VC1;
          cnt_d   = 4'd1;
        end
      end
      OWN_VC0: begin
        if (e0 && ((cnt_q < W0) || !e1)) begin
          gnt0  = 1'b1;
          cnt_d = sat_inc(cnt_q, W0);
        end else if (e1) begin
          gnt1    = 1'b1;
          state_d = OWN_VC1;
          cnt_d   = 4'd1;
        end else begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end
      end
      OWN_VC1: begin
        if (e1 && ((cnt_q < W1) || !e0)) begin
          gnt1  = 1'b1;
          cnt_d = sat_inc(cnt_q, W1);
        end else if (e0) begin
          gnt0    = 1'b1;
          state_d = OWN_VC0;
          cnt_d   = 4'd1;
        end else begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
`endif
  end

  // Route the granted head word; with no grant the output word holds.
  always_comb begin
    any_gnt   = gnt0 | gnt1;
    gnt_word  = gnt1 ? arb.vc1_data : arb.vc0_data;
    d1_push_d = any_gnt &  gnt_word[DEST_BIT];
    d0_push_d = any_gnt & ~gnt_word[DEST_BIT];
    data_d    = any_gnt ? gnt_word : data_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      d0_push_q <= 1'b0;
      d1_push_q <= 1'b0;
      data_q    <= '0;
      idle_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      d0_push_q <= d0_push_d;
      d1_push_q <= d1_push_d;
      data_q    <= data_d;
      idle_q    <= (state_d == IDLE);
    end
  end

  assign arb.vc0_pop  = gnt0 & ~reset;
  assign arb.vc1_pop  = gnt1 & ~reset;
  assign arb.d0_push  = d0_push_q;
  assign arb.d1_push  = d1_push_q;
  assign arb.data_out = data_q;
  assign arb.arb_idle = idle_q;

endmodule

// File: tb/tb_vc_arbiter.sv
// Randomized bench for vc_arbiter: queue-backed FIFO emulation plus a grant-history reference model.
module tb_vc_arbiter;
  localparam int DW = 6;
  localparam int DB = 4;
  localparam int W0 = 3;
  localparam int W1 = 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vc_arbiter_if #(.DATA_WIDTH(DW)) bus ();

  vc_arbiter #(
    .DATA_WIDTH(DW),
    .DEST_BIT  (DB),
    .WEIGHT_VC0(W0),
    .WEIGHT_VC1(W1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .arb  (bus)
  );

  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Reference: who was granted last (-1 none) and how many grants in a row it has had.
  int            m_owner = -1;
  int            m_run   = 0;
  logic          exp_d0   = 1'b0;
  logic          exp_d1   = 1'b0;
  logic [DW-1:0] exp_data = '0;
  logic          exp_idle = 1'b1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit elig(input int vc);
    logic [DW-1:0] w;
    if (vc == 0) begin
      if (q0.size() == 0) return 1'b0;
      w = q0[0];
    end else begin
      if (q1.size() == 0) return 1'b0;
      w = q1[0];
    end
    return bus.active_in && !(w[DB] ? bus.d1_almost_full : bus.d0_almost_full);
  endfunction

  function automatic int pick(input bit a0, input bit a1);
    if (!a0 && !a1) return -1;
`ifdef VC_ARB_STRICT_PRIO_EN
    return a0 ? 0 : 1;
`else
    if (m_owner == 0 && a0 && (m_run < W0 || !a1)) return 0;
    if (m_owner == 1 && a1 && (m_run < W1 || !a0)) return 1;
    if (m_owner == 0) return 1;
    if (m_owner == 1) return 0;
    return a0 ? 0 : 1;
`endif
  endfunction

  task automatic drive_heads();
    bus.vc0_empty = (q0.size() == 0);
    bus.vc1_empty = (q1.size() == 0);
    bus.vc0_data  = (q0.size() != 0) ? q0[0] : DW'($urandom);
    bus.vc1_data  = (q1.size() != 0) ? q1[0] : DW'($urandom);
  endtask

  task automatic model_reset();
    m_owner  = -1;
    m_run    = 0;
    exp_d0   = 1'b0;
    exp_d1   = 1'b0;
    exp_data = '0;
    exp_idle = 1'b1;
  endtask

  // Entered just after a rising edge; returns just after the next one.
  task automatic run_cycle();
    int g;
    bit a0, a1;
    logic [DW-1:0] w;
    drive_heads();
    #2;
    a0 = elig(0);
    a1 = elig(1);
    g  = pick(a0, a1);
    check_eq("vc0_pop", 32'(bus.vc0_pop), 32'(g == 0));
    check_eq("vc1_pop", 32'(bus.vc1_pop), 32'(g == 1));
    @(posedge clk);
    w = '0;
    if (g == 0) w = q0.pop_front();
    else if (g == 1) w = q1.pop_front();
    if (g < 0) begin
      m_owner = -1;
      m_run   = 0;
      exp_d0  = 1'b0;
      exp_d1  = 1'b0;
    end else begin
      if (g == m_owner) m_run = (m_run + 1 > ((g == 0) ? W0 : W1)) ? ((g == 0) ? W0 : W1) : m_run + 1;
      else begin
        m_owner = g;
        m_run   = 1;
      end
      exp_d0   = !w[DB];
      exp_d1   = w[DB];
      exp_data = w;
    end
    exp_idle = (g < 0);
    #1;
    check_eq("d0_push", 32'(bus.d0_push), 32'(exp_d0));
    check_eq("d1_push", 32'(bus.d1_push), 32'(exp_d1));
    check_eq("data_out", 32'(bus.data_out), 32'(exp_data));
    check_eq("arb_idle", 32'(bus.arb_idle), 32'(exp_idle));
  endtask

  task automatic drain();
    for (int i = 0; i < 64 && (q0.size() + q1.size()) != 0; i++) run_cycle();
    check_eq("drain_left", 32'(q0.size() + q1.size()), 32'd0);
  endtask

  initial begin
    reset              = 1'b1;
    bus.active_in      = 1'b1;
    bus.d0_almost_full = 1'b0;
    bus.d1_almost_full = 1'b0;
    drive_heads();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_d0_push", 32'(bus.d0_push), 32'd0);
    check_eq("rst_d1_push", 32'(bus.d1_push), 32'd0);
    check_eq("rst_data", 32'(bus.data_out), 32'd0);
    check_eq("rst_idle", 32'(bus.arb_idle), 32'd1);
    reset = 1'b0;

    // Weighted round-robin, everything to D0.
    for (int i = 0; i < 8; i++) begin
      q0.push_back(DW'($urandom) & ~(DW'(1) << DB));
      q1.push_back(DW'($urandom) & ~(DW'(1) << DB));
    end
    drain();

    // Per-word routing from consecutive VC0 words.
    q0.push_back(6'h10);
    q0.push_back(6'h01);
    q0.push_back(6'h12);
    drain();
    run_cycle();

    // A VC stalled on D1 must not hold up the other VC.
    bus.d1_almost_full = 1'b1;
    q0.push_back(6'h10);
    for (int i = 0; i < 4; i++) q1.push_back(6'h02);
    for (int i = 0; i < 5; i++) run_cycle();
    bus.d1_almost_full = 1'b0;
    drain();

    // active_in drops mid-stream.
    for (int i = 0; i < 6; i++) q0.push_back(DW'($urandom));
    repeat (2) run_cycle();
    bus.active_in = 1'b0;
    repeat (3) run_cycle();
    bus.active_in = 1'b1;
    drain();

    // Asynchronous reset with words queued and a push in flight.
    for (int i = 0; i < 4; i++) begin
      q0.push_back(DW'($urandom));
      q1.push_back(DW'($urandom));
    end
    repeat (2) run_cycle();
    reset = 1'b1;
    #1;
    check_eq("arst_d0_push", 32'(bus.d0_push), 32'd0);
    check_eq("arst_d1_push", 32'(bus.d1_push), 32'd0);
    check_eq("arst_data", 32'(bus.data_out), 32'd0);
    check_eq("arst_idle", 32'(bus.arb_idle), 32'd1);
    check_eq("arst_vc0_pop", 32'(bus.vc0_pop), 32'd0);
    check_eq("arst_vc1_pop", 32'(bus.vc1_pop), 32'd0);
    @(posedge clk);
    #1;
    check_eq("rst_hold_vc0_pop", 32'(bus.vc0_pop), 32'd0);
    check_eq("rst_hold_idle", 32'(bus.arb_idle), 32'd1);
    reset = 1'b0;
    model_reset();
    drain();

    // Randomized traffic with flow control and gating.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 2) != 0 && q0.size() < 12) q0.push_back(DW'($urandom));
      if ($urandom_range(0, 2) != 0 && q1.size() < 12) q1.push_back(DW'($urandom));
      bus.active_in      = ($urandom_range(0, 9) != 0);
      bus.d0_almost_full = ($urandom_range(0, 3) == 0);
      bus.d1_almost_full = ($urandom_range(0, 3) == 0);
      run_cycle();
    end
    bus.active_in      = 1'b1;
    bus.d0_almost_full = 1'b0;
    bus.d1_almost_full = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
